pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 138 +++++++++++++
 tb/tb_pc_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch stage: one outstanding bus request, redirect and misaligned-PC handling
module pc_fetch #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RST_ADDR = '0,
   parameter logic [XLEN-1:0]  NOP_INST = XLEN'(32'h0000_0013)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pipe_stall,
   input  logic            trap_flag,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            ex_is_mret_inst,
   input  logic [XLEN-1:0] mret_pc,
   input  logic            ex_bj_flag,
   input  logic [XLEN-1:0] ex_bj_pc,
   output logic            ibus_req,
   output logic [XLEN-1:0] ibus_addr,
   input  logic            ibus_gnt,
   input  logic            ibus_rvalid,
   input  logic [XLEN-1:0] ibus_rdata,
   output logic            if_out_valid,
   input  logic            id_allowin,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_inst,
   output logic            if_exp_flag,
   output logic            if_inst_addr_misal
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

   state_e          state_q;
   logic [XLEN-1:0] fetch_pc_q;
   logic            discard_q;
   logic            out_valid_q;
   logic [XLEN-1:0] if_pc_q;
   logic [XLEN-1:0] if_inst_q;
   logic            exp_q;
   logic            misal_q;

   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            pc_misal;
   logic            accept;

   assign redirect = trap_flag | ex_is_mret_inst | ex_bj_flag;
   assign pc_misal = |fetch_pc_q[1:0];
   assign accept   = id_allowin & ~pipe_stall;

   always_comb begin
      redirect_pc = ex_bj_pc;
      if (trap_flag)
         redirect_pc = trap_pc;
      else if (ex_is_mret_inst)
         redirect_pc = mret_pc;
   end

   // A misaligned PC never reaches the bus; it is turned into an exception in HOLD.
   assign ibus_req           = (state_q == S_REQ) & ~pc_misal;
   assign ibus_addr          = fetch_pc_q;
   assign if_out_valid       = out_valid_q;
   assign if_pc              = if_pc_q;
   assign if_inst            = if_inst_q;
   assign if_exp_flag        = exp_q;
   assign if_inst_addr_misal = misal_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         fetch_pc_q  <= RST_ADDR;
         discard_q   <= 1'b0;
         out_valid_q <= 1'b0;
         if_pc_q     <= RST_ADDR;
         if_inst_q   <= NOP_INST;
         exp_q       <= 1'b0;
         misal_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q <= S_REQ;
               if (redirect)
                  fetch_pc_q <= redirect_pc;
            end
            S_REQ: begin
               if (redirect) begin
                  fetch_pc_q <= redirect_pc;
                  if (ibus_req && ibus_gnt) begin
                     discard_q <= 1'b1;
                     state_q   <= S_WAIT;
                  end
               end else if (pc_misal) begin
                  state_q     <= S_HOLD;
                  out_valid_q <= 1'b1;
                  if_pc_q     <= fetch_pc_q;
                  if_inst_q   <= NOP_INST;
                  exp_q       <= 1'b1;
                  misal_q     <= 1'b1;
               end else if (ibus_gnt) begin
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (ibus_rvalid) begin
                  if (redirect || discard_q) begin
                     // Response belongs to a flushed path: drop it and refetch.
                     discard_q <= 1'b0;
                     state_q   <= S_REQ;
                     if (redirect)
                        fetch_pc_q <= redirect_pc;
                  end else begin
                     state_q     <= S_HOLD;
                     out_valid_q <= 1'b1;
                     if_pc_q     <= fetch_pc_q;
                     if_inst_q   <= ibus_rdata;
                     exp_q       <= 1'b0;
                     misal_q     <= 1'b0;
                  end
               end else if (redirect) begin
                  discard_q  <= 1'b1;
                  fetch_pc_q <= redirect_pc;
               end
            end
            S_HOLD: begin
               if (redirect) begin
                  fetch_pc_q  <= redirect_pc;
                  out_valid_q <= 1'b0;
                  state_q     <= S_REQ;
               end else if (accept) begin
                  fetch_pc_q  <= fetch_pc_q + XLEN'(4);
                  out_valid_q <= 1'b0;
                  state_q     <= S_REQ;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pipe_stall;
   logic        trap_flag;
   logic [31:0] trap_pc;
   logic        ex_is_mret_inst;
   logic [31:0] mret_pc;
   logic        ex_bj_flag;
   logic [31:0] ex_bj_pc;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_gnt;
   logic        ibus_rvalid;
   logic [31:0] ibus_rdata;
   logic        if_out_valid;
   logic        id_allowin;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_exp_flag;
   logic        if_inst_addr_misal;

   int n_checks = 0;
   int n_fail   = 0;

   pc_fetch dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .pipe_stall         (pipe_stall),
      .trap_flag          (trap_flag),
      .trap_pc            (trap_pc),
      .ex_is_mret_inst    (ex_is_mret_inst),
      .mret_pc            (mret_pc),
      .ex_bj_flag         (ex_bj_flag),
      .ex_bj_pc           (ex_bj_pc),
      .ibus_req           (ibus_req),
      .ibus_addr          (ibus_addr),
      .ibus_gnt           (ibus_gnt),
      .ibus_rvalid        (ibus_rvalid),
      .ibus_rdata         (ibus_rdata),
      .if_out_valid       (if_out_valid),
      .id_allowin         (id_allowin),
      .if_pc              (if_pc),
      .if_inst            (if_inst),
      .if_exp_flag        (if_exp_flag),
      .if_inst_addr_misal (if_inst_addr_misal)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req"},   ibus_req, 0);
      check_eq({tag, "_addr"},  ibus_addr, 32'h0);
      check_eq({tag, "_valid"}, if_out_valid, 0);
      check_eq({tag, "_pc"},    if_pc, 32'h0);
      check_eq({tag, "_inst"},  if_inst, 32'h13);
      check_eq({tag, "_exp"},   if_exp_flag, 0);
      check_eq({tag, "_misal"}, if_inst_addr_misal, 0);
   endtask

   // Starts at a REQ-state negedge, ends at the negedge where the instruction is presented.
   task automatic bus_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
      check_eq({tag, "_req"},  ibus_req, 1);
      check_eq({tag, "_addr"}, ibus_addr, addr);
      ibus_gnt = 1'b1;
      tick();
      ibus_gnt = 1'b0;
      check_eq({tag, "_wait_req"},   ibus_req, 0);
      check_eq({tag, "_wait_valid"}, if_out_valid, 0);
      ibus_rvalid = 1'b1;
      ibus_rdata  = data;
      tick();
      ibus_rvalid = 1'b0;
      check_eq({tag, "_valid"}, if_out_valid, 1);
      check_eq({tag, "_pc"},    if_pc, addr);
      check_eq({tag, "_inst"},  if_inst, data);
      check_eq({tag, "_exp"},   if_exp_flag, 0);
      check_eq({tag, "_misal"}, if_inst_addr_misal, 0);
   endtask

   initial begin
      rst_n = 1'b0; pipe_stall = 1'b0; id_allowin = 1'b1;
      trap_flag = 1'b0; trap_pc = '0; ex_is_mret_inst = 1'b0; mret_pc = '0;
      ex_bj_flag = 1'b0; ex_bj_pc = '0;
      ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0;
      repeat (3) tick();
      check_reset_outputs("rst");

      rst_n = 1'b1;
      check_eq("idle_req", ibus_req, 0);
      tick();

      // Basic fetch with minimum latency, then sequential next address
      bus_fetch("f0", 32'h0, 32'h0000_0093);
      tick();
      check_eq("f0_valid_drop", if_out_valid, 0);

      // Stall in HOLD
      bus_fetch("f1", 32'h4, 32'h0010_0113);
      pipe_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("stall_valid", if_out_valid, 1);
         check_eq("stall_pc",    if_pc, 32'h4);
         check_eq("stall_inst",  if_inst, 32'h0010_0113);
         check_eq("stall_req",   ibus_req, 0);
      end
      pipe_stall = 1'b0;
      tick();
      check_eq("stall_next_req",  ibus_req, 1);
      check_eq("stall_next_addr", ibus_addr, 32'h8);

      // Redirect while waiting; response two cycles later is dropped
      ibus_gnt = 1'b1;
      tick();
      ibus_gnt = 1'b0;
      ex_bj_flag = 1'b1; ex_bj_pc = 32'h100;
      tick();
      ex_bj_flag = 1'b0;
      check_eq("wredir_req", ibus_req, 0);
      tick();
      ibus_rvalid = 1'b1; ibus_rdata = 32'hDEAD_BEEF;
      tick();
      ibus_rvalid = 1'b0;
      check_eq("wredir_valid", if_out_valid, 0);
      check_eq("wredir_req2",  ibus_req, 1);
      check_eq("wredir_addr",  ibus_addr, 32'h100);
      tick();
      check_eq("wredir_valid2", if_out_valid, 0);

      // Redirect priority
      trap_flag = 1'b1; trap_pc = 32'h80;
      ex_is_mret_inst = 1'b1; mret_pc = 32'h300;
      ex_bj_flag = 1'b1; ex_bj_pc = 32'h200;
      tick();
      check_eq("prio_trap", ibus_addr, 32'h80);
      trap_flag = 1'b0;
      tick();
      check_eq("prio_mret", ibus_addr, 32'h300);
      ex_is_mret_inst = 1'b0;
      tick();
      check_eq("prio_bj", ibus_addr, 32'h200);

      // Misaligned target
      ex_bj_pc = 32'h102;
      tick();
      ex_bj_flag = 1'b0;
      check_eq("misal_noreq", ibus_req, 0);
      tick();
      check_eq("misal_valid", if_out_valid, 1);
      check_eq("misal_pc",    if_pc, 32'h102);
      check_eq("misal_inst",  if_inst, 32'h13);
      check_eq("misal_exp",   if_exp_flag, 1);
      check_eq("misal_cause", if_inst_addr_misal, 1);
      check_eq("misal_req",   ibus_req, 0);

      // Redirect beats acceptance, then wrap of fetch_pc
      ex_bj_flag = 1'b1; ex_bj_pc = 32'hFFFF_FFFC;
      tick();
      ex_bj_flag = 1'b0;
      check_eq("hredir_valid", if_out_valid, 0);
      bus_fetch("fwrap", 32'hFFFF_FFFC, 32'h0050_0093);
      tick();
      check_eq("wrap_req",  ibus_req, 1);
      check_eq("wrap_addr", ibus_addr, 32'h0);

      // Redirect coincident with grant
      ibus_gnt = 1'b1; ex_bj_flag = 1'b1; ex_bj_pc = 32'h40;
      tick();
      ibus_gnt = 1'b0; ex_bj_flag = 1'b0;
      check_eq("gredir_req", ibus_req, 0);
      ibus_rvalid = 1'b1; ibus_rdata = 32'h1111_1111;
      tick();
      ibus_rvalid = 1'b0;
      check_eq("gredir_valid", if_out_valid, 0);
      check_eq("gredir_addr",  ibus_addr, 32'h40);
      check_eq("gredir_inst",  if_inst, 32'h0050_0093);

      // Redirect coincident with response
      ibus_gnt = 1'b1;
      tick();
      ibus_gnt = 1'b0;
      ibus_rvalid = 1'b1; ibus_rdata = 32'h2222_2222;
      trap_flag = 1'b1; trap_pc = 32'h80;
      tick();
      ibus_rvalid = 1'b0; trap_flag = 1'b0;
      check_eq("rredir_valid", if_out_valid, 0);
      check_eq("rredir_req",   ibus_req, 1);
      check_eq("rredir_addr",  ibus_addr, 32'h80);

      // Asynchronous reset in WAIT, stale response after release
      ibus_gnt = 1'b1;
      tick();
      ibus_gnt = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("arst");
      tick();
      rst_n = 1'b1;
      ibus_rvalid = 1'b1; ibus_rdata = 32'h3333_3333;
      tick();
      ibus_rvalid = 1'b0;
      check_eq("stale_valid", if_out_valid, 0);
      check_eq("stale_inst",  if_inst, 32'h13);
      bus_fetch("fpost", 32'h0, 32'h4444_4444);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
